mult_div_sequencer: RTL and testbench
=====================================

// Module: mult_div_sequencer
// PURPOSE
//  Multicycle sequencer for MULT/DIV instructions in the multicycle CPU.
//  Unidade_Controle pulses start with operands from A/B. This block runs a
//  WIDTH-iteration radix-2 Booth multiply, or a sign-magnitude restoring
//  divide, then writes the HI/LO registers. Unidade_Controle stalls in its
//  MULT/DIV state until done.
// PARAMETERS
//  WIDTH    32   operand width; HI and LO are each WIDTH bits
// PORTS
//  clk          in   1      clock, all state changes on rising edge
//  reset        in   1      synchronous, active-high
//  start        in   1      request; sampled only in IDLE
//  op           in   1      0 = MULT (signed), 1 = DIV (signed)
//  a            in   WIDTH  multiplicand / dividend (from reg A)
//  b            in   WIDTH  multiplier / divisor (from reg B)
//  busy         out  1      operation in progress
//  done         out  1      one-cycle pulse: operation finished
//  div_zero     out  1      one-cycle pulse with done: DIV with b == 0
//  hi_lo_write  out  1      one-cycle pulse: hi/lo hold a new result
//  hi           out  WIDTH  HI register (MULT upper half / DIV remainder)
//  lo           out  WIDTH  LO register (MULT lower half / DIV quotient)
// BEHAVIOUR
//  Reset: state = IDLE; busy, done, div_zero, hi_lo_write = 0; hi = lo = 0.
//  Reset wins over every other input.
//  Reset mid-operation aborts the operation: no done, hi/lo cleared.
//  States: IDLE -> MULT | DIV -> FINISH -> IDLE. DIV with b == 0 goes
//  IDLE -> FINISH directly.
//  IDLE:
//   - start = 1 at edge E0 latches a, b, op; busy = 1 from E0.
//   - Iteration counter is loaded with WIDTH.
//   - start while busy is ignored; operands are not re-latched.
//  MULT:
//   - One Booth step per edge, E1..E_WIDTH.
//   - Accumulator is {hi_acc, lo_acc, q_-1}: 2*WIDTH+1 bits, arithmetic
//     shift right.
//  DIV:
//   - Operate on |a| and |b| as unsigned values; one restore step per edge.
//   - Quotient sign = sign(a) XOR sign(b).
//   - Remainder takes the sign of a; quotient truncates toward zero.
//   - a = INT_MIN, b = -1: lo = INT_MIN, hi = 0 (wraps, no flag).
//  FINISH (edge E_WIDTH+1):
//   - hi/lo updated; done = hi_lo_write = 1 for exactly one cycle.
//   - busy = 0 from this edge.
//   - Next state is IDLE.
//   - start may be accepted on the very next edge.
//  Divide by zero:
//   - At E1: done = div_zero = 1 for one cycle, busy = 0.
//   - hi_lo_write = 0; hi/lo keep their previous values.
//  Latency:
//   - done is high in the cycle following edge E_WIDTH+1, i.e. WIDTH+1
//     edges after the start edge.
//   - Divide by zero: 1 edge after the start edge.
//  hi/lo hold their last value indefinitely; they change only in FINISH or
//  on reset.
//  Iteration counter width: $clog2(WIDTH+1); no wrap within an operation.
// TESTING
//  1. MULT a=7, b=0xFFFFFFFD (-3) -> after 33 edges done=1,
//     hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  2. MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000, hi_lo_write=1.
//  3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  4. DIV a=5, b=0 -> 1 edge later done=div_zero=1, hi_lo_write=0,
//     hi/lo unchanged.
//  5. Start MULT 3*4, pulse start with a=9 at edge E5 -> ignored;
//     result lo=12, hi=0.
//  6. Start DIV 100/7, assert reset at E10 -> busy=0, hi=lo=0, no done;
//     a new DIV 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/mult_div_sequencer.sv
// Multicycle MULT/DIV sequencer: radix-2 Booth multiply or sign-magnitude restoring
// divide, one step per clock, result written to HI/LO with a one-cycle done pulse.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_lo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  // state    | meaning
  // S_IDLE   | waiting for start, hi/lo hold last result
  // S_MULT   | one Booth step per edge
  // S_DIV    | one restoring-divide step per edge
  // S_FINISH | write hi/lo (or flag divide by zero), pulse done
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             acc_x_q, acc_x_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             op_q, op_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   m_ext, booth_sum, rem_sh, trial;

  always_comb begin
    m_ext  = {m_q[WIDTH-1], m_q};
    rem_sh = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, m_q};
    case ({acc_lo_q[0], acc_x_q})
      2'b01:   booth_sum = acc_hi_q + m_ext;
      2'b10:   booth_sum = acc_hi_q - m_ext;
      default: booth_sum = acc_hi_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    acc_x_d    = acc_x_q;
    m_d        = m_q;
    op_d       = op_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    wr_d       = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          cnt_d    = CW'(WIDTH);
          acc_hi_d = '0;
          acc_x_d  = 1'b0;
          dz_d     = 1'b0;
          if (!op) begin
            m_d      = a;
            acc_lo_d = b;
            state_d  = S_MULT;
          end else if (b == '0) begin
            dz_d    = 1'b1;
            state_d = S_FINISH;
          end else begin
            // Divide on magnitudes; signs are reapplied in FINISH
            m_d      = b[WIDTH-1] ? ('0 - b) : b;
            acc_lo_d = a[WIDTH-1] ? ('0 - a) : a;
            qneg_d   = a[WIDTH-1] ^ b[WIDTH-1];
            rneg_d   = a[WIDTH-1];
            state_d  = S_DIV;
          end
        end
      end
      S_MULT: begin
        // One extra guard bit in hi keeps INT_MIN operands from overflowing
        acc_hi_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        acc_lo_d = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
        acc_x_d  = acc_lo_q[0];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FINISH;
      end
      S_DIV: begin
        if (!trial[WIDTH]) begin
          acc_hi_d = trial;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = rem_sh;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else begin
          wr_d = 1'b1;
          if (!op_q) begin
            hi_d = acc_hi_q[WIDTH-1:0];
            lo_d = acc_lo_q;
          end else begin
            hi_d = rneg_q ? ('0 - acc_hi_q[WIDTH-1:0]) : acc_hi_q[WIDTH-1:0];
            lo_d = qneg_q ? ('0 - acc_lo_q) : acc_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      acc_x_q    <= 1'b0;
      m_q        <= '0;
      op_q       <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      wr_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      acc_x_q    <= acc_x_d;
      m_q        <= m_d;
      op_q       <= op_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      wr_q       <= wr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_zero    = div_zero_q;
  assign hi_lo_write = wr_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever done is presented.
module tb_mult_div_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero, hi_lo_write;
  logic [W-1:0] hi, lo;

  mult_div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi_lo_write(hi_lo_write),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk_pulse = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // Monitor: compare every done against the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (chk_pulse) chk("done_one_cycle", 64'(done), 64'd0);
    chk_pulse = 0;
    if (done) begin
      chk_pulse = 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.name, "_div_zero"}, 64'(div_zero), 64'(e.dz));
        chk({e.name, "_hi_lo_write"}, 64'(hi_lo_write), 64'(!e.dz));
        chk({e.name, "_latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
        chk({e.name, "_busy_low"}, 64'(busy), 64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge
  task automatic issue(input string nm, input bit o, input logic [W-1:0] aa, bb,
                       input logic [W-1:0] ehi, elo, input bit edz, input bit push);
    exp_t e;
    op = o; a = aa; b = bb; start = 1'b1;
    if (push) begin
      e.name = nm; e.hi = ehi; e.lo = elo; e.dz = edz;
      e.lat = edz ? 1 : W + 1;
      e.start_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_after_start"}, 64'(busy), 64'(!edz || 1'b1));
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_hi_lo_write", 64'(hi_lo_write), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue("mul_7_m3", 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1);
    wait_done("mul_7_m3");
    // back-to-back: start on the edge right after done
    issue("mul_min_min", 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 1);
    wait_done("mul_min_min");
    issue("mul_m1_m1", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 1);
    wait_done("mul_m1_m1");
    issue("mul_max_max", 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0, 1);
    wait_done("mul_max_max");
    issue("mul_min_max", 0, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 0, 1);
    wait_done("mul_min_max");
    issue("div_m7_2", 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1);
    wait_done("div_m7_2");
    @(negedge clk);
    issue("div_5_0", 1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 1);
    wait_done("div_5_0");
    @(negedge clk);
    issue("div_7_m2", 1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 1);
    wait_done("div_7_m2");
    issue("div_m7_m2", 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 0, 1);
    wait_done("div_m7_m2");
    issue("div_min_m1", 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1);
    wait_done("div_min_m1");
    issue("div_100_7", 1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1);
    wait_done("div_100_7");

    // start pulse while busy is ignored
    issue("mul_3_4", 0, 32'd3, 32'd4, 32'd0, 32'd12, 0, 1);
    repeat (4) @(negedge clk);
    a = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_3_4");
    @(negedge clk);

    // reset at E10 aborts a DIV
    issue("div_abort", 1, 32'd100, 32'd7, 32'd0, 32'd0, 0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done_busy", 64'(busy), 64'd0);
    issue("div_100_7_again", 1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1);
    wait_done("div_100_7_again");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
